// File: rtl/cache_fill_seq_if.sv
// rtl/cache_fill_seq_if.sv - handshake and cache-RAM bus bundle for cache_fill_seq
//
// Groups every cache_fill_seq port except clk and reset_l.
//   fill_*    : fill request/ack from the miss handler (way, address bits 27:35)
//   mem_*     : memory word stream into the sequencer (valid/rdy, data, parity)
//   cpu_rd_*  : CPU cache read request/grant
//   cache_*, csh_* : cache RAM address, way select, write strobe, read enable, write data
//   busy_h, fill_done_h, par_err_h : status
// modport slave is the sequencer; modport master is whoever drives the requests.
interface cache_fill_seq_if;
  logic        fill_req_h;
  logic [1:0]  fill_way_h;
  logic [8:0]  fill_adr_h;
  logic        fill_ack_h;
  logic        mem_valid_h;
  logic [35:0] mem_data_h;
  logic        mem_par_h;
  logic        mem_rdy_h;
  logic        cpu_rd_req_h;
  logic [1:0]  cpu_rd_way_h;
  logic [8:0]  cpu_rd_adr_h;
  logic        cpu_rd_gnt_h;
  logic [8:0]  cache_adr_h;
  logic [3:0]  csh_sel_l;
  logic        cache_wr_l;
  logic        csh_en_csh_data_l;
  logic [35:0] mem_to_cache_h;
  logic        csh_par_bit_in_h;
  logic        busy_h;
  logic        fill_done_h;
  logic        par_err_h;

  modport slave (
    input  fill_req_h, fill_way_h, fill_adr_h,
    input  mem_valid_h, mem_data_h, mem_par_h,
    input  cpu_rd_req_h, cpu_rd_way_h, cpu_rd_adr_h,
    output fill_ack_h, mem_rdy_h, cpu_rd_gnt_h,
    output cache_adr_h, csh_sel_l, cache_wr_l, csh_en_csh_data_l,
    output mem_to_cache_h, csh_par_bit_in_h,
    output busy_h, fill_done_h, par_err_h
  );

  modport master (
    output fill_req_h, fill_way_h, fill_adr_h,
    output mem_valid_h, mem_data_h, mem_par_h,
    output cpu_rd_req_h, cpu_rd_way_h, cpu_rd_adr_h,
    input  fill_ack_h, mem_rdy_h, cpu_rd_gnt_h,
    input  cache_adr_h, csh_sel_l, cache_wr_l, csh_en_csh_data_l,
    input  mem_to_cache_h, csh_par_bit_in_h,
    input  busy_h, fill_done_h, par_err_h
  );
endinterface

// File: rtl/cache_fill_seq.sv
// rtl/cache_fill_seq.sv - four-word critical-word-first cache fill sequencer
//
// Ports:
//   clk      : single clock, rising edge
//   reset_l  : asynchronous active-low reset
//   bus      : cache_fill_seq_if.slave (fill request, memory stream, CPU read,
//              cache RAM controls, status)
// Every output is a register; the value seen in a state is loaded on the edge
// that enters that state.
module cache_fill_seq #(
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              reset_l,
  cache_fill_seq_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, RD, FWAIT, FWRITE, FDONE} state_t;

  state_t      state_q;
  logic [1:0]  way_q;
  logic [6:0]  line_q;      // latched address bits 27:33
  logic [1:0]  cnt_q;       // word within the line, wraps mod 4
  logic [1:0]  wcnt_q;      // number of words already written
  logic        fill_ack_q;
  logic        mem_rdy_q;
  logic        rd_gnt_q;
  logic [8:0]  cache_adr_q;
  logic [3:0]  sel_q;
  logic        cache_wr_q;
  logic        csh_en_q;
  logic [35:0] data_q;
  logic        par_q;
  logic        busy_q;
  logic        fill_done_q;
  logic        par_err_q;

  function automatic logic [3:0] sel_low(input logic [1:0] way);
    sel_low = ~(4'b0001 << way);
  endfunction

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      way_q       <= '0;
      line_q      <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      fill_ack_q  <= 1'b0;
      mem_rdy_q   <= 1'b0;
      rd_gnt_q    <= 1'b0;
      cache_adr_q <= '0;
      sel_q       <= 4'b1111;
      cache_wr_q  <= 1'b1;
      csh_en_q    <= 1'b1;
      data_q      <= '0;
      par_q       <= 1'b0;
      busy_q      <= 1'b0;
      fill_done_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      // single-cycle pulses fall unless re-asserted below
      fill_ack_q  <= 1'b0;
      rd_gnt_q    <= 1'b0;
      fill_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // a fill outranks a read; a held read is picked up once the fill ends
          if (bus.fill_req_h) begin
            state_q    <= FWAIT;
            busy_q     <= 1'b1;
            fill_ack_q <= 1'b1;
            way_q      <= bus.fill_way_h;
            line_q     <= bus.fill_adr_h[8:2];
            cnt_q      <= bus.fill_adr_h[1:0];
            wcnt_q     <= '0;
            mem_rdy_q  <= 1'b1;
            par_err_q  <= 1'b0;
          end else if (bus.cpu_rd_req_h) begin
            state_q     <= RD;
            busy_q      <= 1'b1;
            rd_gnt_q    <= 1'b1;
            csh_en_q    <= 1'b0;
            sel_q       <= sel_low(bus.cpu_rd_way_h);
            cache_adr_q <= bus.cpu_rd_adr_h;
          end
        end
        RD: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          csh_en_q <= 1'b1;
          sel_q    <= 4'b1111;
        end
        FWAIT: begin
          if (bus.mem_valid_h) begin
            state_q     <= FWRITE;
            data_q      <= bus.mem_data_h;
            par_q       <= bus.mem_par_h;
            mem_rdy_q   <= 1'b0;
            cache_wr_q  <= 1'b0;
            sel_q       <= sel_low(way_q);
            cache_adr_q <= {line_q, cnt_q};
          end
        end
        FWRITE: begin
          cache_wr_q <= 1'b1;
          sel_q      <= 4'b1111;
          cnt_q      <= cnt_q + 2'd1;
          wcnt_q     <= wcnt_q + 2'd1;
          // odd parity over data plus parity bit; error is sticky until next accept
          if (!(^{data_q, par_q})) par_err_q <= 1'b1;
          if (wcnt_q == 2'(NWORDS - 1)) begin
            state_q     <= FDONE;
            fill_done_q <= 1'b1;
          end else begin
            state_q   <= FWAIT;
            mem_rdy_q <= 1'b1;
          end
        end
        FDONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fill_ack_h        = fill_ack_q;
  assign bus.mem_rdy_h         = mem_rdy_q;
  assign bus.cpu_rd_gnt_h      = rd_gnt_q;
  assign bus.cache_adr_h       = cache_adr_q;
  assign bus.csh_sel_l         = sel_q;
  assign bus.cache_wr_l        = cache_wr_q;
  assign bus.csh_en_csh_data_l = csh_en_q;
  assign bus.mem_to_cache_h    = data_q;
  assign bus.csh_par_bit_in_h  = par_q;
  assign bus.busy_h            = busy_q;
  assign bus.fill_done_h       = fill_done_q;
  assign bus.par_err_h         = par_err_q;

endmodule

// File: tb/tb_cache_fill_seq.sv
// tb/tb_cache_fill_seq.sv - self-checking bench for cache_fill_seq
module tb_cache_fill_seq;
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  cache_fill_seq_if bus();
  cache_fill_seq #(.NWORDS(4)) dut (.clk(clk), .reset_l(reset_l), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] wdata(input int k, input logic [8:0] adr);
    wdata = {4'(k + 1), 23'h5A5A5, adr} ^ 36'h0_F0F0_0F0F;
  endfunction

  typedef struct {
    logic [1:0] way;
    logic [8:0] adr;
    int         bad;
    int         gap;
    logic [8:0] e_adr [4];
    logic [3:0] e_sel;
    logic       e_perr;
  } fill_vec_t;

  typedef struct {
    logic [1:0] way;
    logic [8:0] adr;
    logic [3:0] e_sel;
  } rd_vec_t;

  fill_vec_t fv [5];
  rd_vec_t   rv [4];

  logic [8:0]  r_adr [4];
  logic [3:0]  r_sel [4];
  logic [35:0] r_dat [4];
  logic        r_par [4];
  int nwr, nack, ndone, ngnt, nen, sel_bad, stall_bad, excl_bad, timed_out;
  int done_cyc, gnt_cyc, ack_cyc;
  logic par_at_ack, par_at_done, par_after_bad;

  task automatic run_fill(input logic [1:0] way, input logic [8:0] adr, input int bad,
                          input int gap, input bit rd_too, input int extra, input int abort_at);
    int wi, gcnt, cyc, post;
    bit stalling, bad_next, done;
    nwr = 0; nack = 0; ndone = 0; ngnt = 0; nen = 0;
    sel_bad = 0; stall_bad = 0; excl_bad = 0; timed_out = 0;
    done_cyc = -1; gnt_cyc = -1; ack_cyc = -1;
    par_at_ack = 1'bx; par_at_done = 1'bx; par_after_bad = 1'bx;
    wi = 0; gcnt = 0; cyc = 0; post = 0; stalling = 0; bad_next = 0; done = 0;
    @(negedge clk);
    bus.fill_req_h = 1'b1;
    bus.fill_way_h = way;
    bus.fill_adr_h = adr;
    if (rd_too) begin
      bus.cpu_rd_req_h = 1'b1;
      bus.cpu_rd_way_h = 2'd1;
      bus.cpu_rd_adr_h = 9'h055;
    end
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bad_next) begin
        par_after_bad = bus.par_err_h;
        bad_next = 0;
      end
      if (stalling && (bus.mem_rdy_h !== 1'b1 || bus.cache_wr_l !== 1'b1)) stall_bad++;
      if (bus.fill_ack_h === 1'b1) begin
        nack++;
        ack_cyc = cyc;
        par_at_ack = bus.par_err_h;
        if (!rd_too) bus.fill_req_h = 1'b0;
      end
      if (bus.cache_wr_l === 1'b0) begin
        if (nwr < 4) begin
          r_adr[nwr] = bus.cache_adr_h;
          r_sel[nwr] = bus.csh_sel_l;
          r_dat[nwr] = bus.mem_to_cache_h;
          r_par[nwr] = bus.csh_par_bit_in_h;
        end
        if (nwr == bad) bad_next = 1;
        nwr++;
      end else if (bus.csh_en_csh_data_l === 1'b1 && bus.csh_sel_l !== 4'b1111) begin
        sel_bad++;
      end
      if (bus.cache_wr_l === 1'b0 && bus.csh_en_csh_data_l === 1'b0) excl_bad++;
      if (bus.cpu_rd_gnt_h === 1'b1) begin
        ngnt++;
        gnt_cyc = cyc;
        bus.cpu_rd_req_h = 1'b0;
      end
      if (bus.csh_en_csh_data_l === 1'b0) nen++;
      if (bus.fill_done_h === 1'b1) begin
        ndone++;
        par_at_done = bus.par_err_h;
        done_cyc = cyc;
        done = 1;
        bus.fill_req_h = 1'b0;
      end
      if (abort_at > 0 && nwr == abort_at) break;
      if (done) begin
        if (post >= extra) break;
        post++;
      end
      if (cyc > 200) begin
        timed_out = 1;
        break;
      end
      stalling = 0;
      if (bus.mem_rdy_h === 1'b1 && wi < 4) begin
        if (gcnt == 0) begin
          bus.mem_valid_h = 1'b1;
          bus.mem_data_h  = wdata(wi, adr);
          bus.mem_par_h   = (wi == bad) ? ^wdata(wi, adr) : ~^wdata(wi, adr);
          wi++;
          gcnt = gap;
        end else begin
          bus.mem_valid_h = 1'b0;
          gcnt--;
          stalling = 1;
        end
      end else begin
        bus.mem_valid_h = 1'b0;
      end
    end
    bus.mem_valid_h  = 1'b0;
    bus.fill_req_h   = 1'b0;
    bus.cpu_rd_req_h = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [1:0] way, input logic [8:0] adr, input logic [3:0] e_sel);
    int extra_g, extra_en;
    bit found;
    found = 0; extra_g = 0; extra_en = 0;
    @(negedge clk);
    bus.cpu_rd_req_h = 1'b1;
    bus.cpu_rd_way_h = way;
    bus.cpu_rd_adr_h = adr;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.cpu_rd_gnt_h === 1'b1) begin
        found = 1;
        chk($sformatf("rd%0d_sel", i), bus.csh_sel_l, e_sel);
        chk($sformatf("rd%0d_adr", i), bus.cache_adr_h, adr);
        chk($sformatf("rd%0d_en", i), bus.csh_en_csh_data_l, 1'b0);
        chk($sformatf("rd%0d_wr", i), bus.cache_wr_l, 1'b1);
        chk($sformatf("rd%0d_busy", i), bus.busy_h, 1'b1);
        bus.cpu_rd_req_h = 1'b0;
      end
    end
    chk($sformatf("rd%0d_granted", i), found, 1'b1);
    bus.cpu_rd_req_h = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.cpu_rd_gnt_h !== 1'b0) extra_g++;
      if (bus.csh_en_csh_data_l !== 1'b1 || bus.cache_wr_l !== 1'b1) extra_en++;
    end
    chk($sformatf("rd%0d_one_pulse", i), extra_g, 0);
    chk($sformatf("rd%0d_idle_after", i), extra_en, 0);
  endtask

  task automatic check_fill(input string tag, input fill_vec_t v);
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_nack"}, nack, 1);
    chk({tag, "_ack_lat"}, ack_cyc, 1);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_nwr"}, nwr, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_adr%0d", tag, k), r_adr[k], v.e_adr[k]);
      chk($sformatf("%s_sel%0d", tag, k), r_sel[k], v.e_sel);
      chk($sformatf("%s_dat%0d", tag, k), r_dat[k], wdata(k, v.adr));
      chk($sformatf("%s_par%0d", tag, k), r_par[k],
          (k == v.bad) ? ^wdata(k, v.adr) : ~^wdata(k, v.adr));
    end
    chk({tag, "_sel_idle"}, sel_bad, 0);
    chk({tag, "_stall"}, stall_bad, 0);
    chk({tag, "_wr_rd_excl"}, excl_bad, 0);
    chk({tag, "_perr_ack"}, par_at_ack, 1'b0);
    chk({tag, "_perr_done"}, par_at_done, v.e_perr);
    if (v.bad >= 0) chk({tag, "_perr_next"}, par_after_bad, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy_h, 1'b0);
    chk({tag, "_sel"}, bus.csh_sel_l, 4'b1111);
    chk({tag, "_wr"}, bus.cache_wr_l, 1'b1);
    chk({tag, "_en"}, bus.csh_en_csh_data_l, 1'b1);
    chk({tag, "_rdy"}, bus.mem_rdy_h, 1'b0);
    chk({tag, "_adr"}, bus.cache_adr_h, 9'h000);
    chk({tag, "_dat"}, bus.mem_to_cache_h, 36'h0);
    chk({tag, "_done"}, bus.fill_done_h, 1'b0);
    chk({tag, "_ack"}, bus.fill_ack_h, 1'b0);
    chk({tag, "_gnt"}, bus.cpu_rd_gnt_h, 1'b0);
    chk({tag, "_perr"}, bus.par_err_h, 1'b0);
  endtask

  initial begin
    int w, d;
    fv[0] = '{2'd2, 9'h1F6, -1, 0, '{9'h1F6, 9'h1F7, 9'h1F4, 9'h1F5}, 4'b1011, 1'b0};
    fv[1] = '{2'd1, 9'h0A1,  1, 0, '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A0}, 4'b1101, 1'b1};
    fv[2] = '{2'd3, 9'h100, -1, 5, '{9'h100, 9'h101, 9'h102, 9'h103}, 4'b0111, 1'b0};
    fv[3] = '{2'd0, 9'h0FF,  3, 1, '{9'h0FF, 9'h0FC, 9'h0FD, 9'h0FE}, 4'b1110, 1'b1};
    fv[4] = '{2'd2, 9'h002, -1, 0, '{9'h002, 9'h003, 9'h000, 9'h001}, 4'b1011, 1'b0};
    rv[0] = '{2'd0, 9'h0A3, 4'b1110};
    rv[1] = '{2'd3, 9'h1FF, 4'b0111};
    rv[2] = '{2'd1, 9'h000, 4'b1101};
    rv[3] = '{2'd2, 9'h155, 4'b1011};

    bus.fill_req_h = 1'b0;   bus.fill_way_h = '0;   bus.fill_adr_h = '0;
    bus.mem_valid_h = 1'b0;  bus.mem_data_h = '0;   bus.mem_par_h = 1'b0;
    bus.cpu_rd_req_h = 1'b0; bus.cpu_rd_way_h = '0; bus.cpu_rd_adr_h = '0;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_l = 1'b1;

    for (int i = 0; i < 4; i++) do_read(i, rv[i].way, rv[i].adr, rv[i].e_sel);

    for (int i = 0; i < 5; i++) begin
      run_fill(fv[i].way, fv[i].adr, fv[i].bad, fv[i].gap, 1'b0, 0, -1);
      check_fill($sformatf("fill%0d", i), fv[i]);
      @(negedge clk);
      chk($sformatf("fill%0d_busy_after", i), bus.busy_h, 1'b0);
    end

    // fill and read requested together; both held while busy
    run_fill(2'd2, 9'h1F6, -1, 0, 1'b1, 4, -1);
    check_fill("coll", fv[0]);
    chk("coll_ngnt", ngnt, 1);
    chk("coll_en_cycles", nen, 1);
    chk("coll_gnt_after_done", (gnt_cyc > done_cyc) && (gnt_cyc <= done_cyc + 2), 1'b1);

    // reset in the middle of a fill, after the second write
    run_fill(2'd1, 9'h0A1, -1, 0, 1'b0, 0, 2);
    chk("abort_nwr", nwr, 2);
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    reset_l = 1'b1;
    w = 0; d = 0;
    bus.mem_valid_h = 1'b1;
    bus.mem_data_h  = 36'h123456789;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.cache_wr_l !== 1'b1) w++;
      if (bus.fill_done_h !== 1'b0 || bus.busy_h !== 1'b0) d++;
    end
    bus.mem_valid_h = 1'b0;
    chk("abort_no_writes", w, 0);
    chk("abort_no_done", d, 0);
    run_fill(fv[0].way, fv[0].adr, fv[0].bad, fv[0].gap, 1'b0, 0, -1);
    check_fill("refill", fv[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
